// File: rtl/param_reg_file_pkg.sv
// param_reg_file_pkg: FSM state encoding and default parameters shared by the register file.
package param_reg_file_pkg;
    typedef enum logic {RF_CLEAR = 1'b0, RF_IDLE = 1'b1} rf_state_e;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_NUM_RD = 2;
    localparam bit DEF_ZERO_REG = 1'b1;
    localparam bit DEF_BYPASS = 1'b1;
endpackage

// File: rtl/param_reg_file_read_port.sv
// rf_read_port: one combinational read port with zero-register masking and write forwarding.
module rf_read_port
    import param_reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter bit ZERO_REG = DEF_ZERO_REG,
    parameter bit BYPASS = DEF_BYPASS
) (
    input  logic              ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] mem [2**ADDR_W],
    input  logic              fwd_en,
    input  logic [ADDR_W-1:0] fwd_addr,
    input  logic [DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0] rd_data
);
    logic zero_hit;
    logic fwd_hit;
    always_comb begin
        zero_hit = ZERO_REG && (rd_addr == '0);
        fwd_hit = BYPASS && fwd_en && (fwd_addr == rd_addr);
        rd_data = (!ready || zero_hit) ? '0 : fwd_hit ? fwd_data : mem[rd_addr];
    end
endmodule

// File: rtl/param_reg_file.sv
// param_reg_file: multi-port register file with a self-clearing sweep after reset or on request.
module param_reg_file
    import param_reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = DEF_NUM_RD,
    parameter bit ZERO_REG = DEF_ZERO_REG,
    parameter bit BYPASS = DEF_BYPASS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] read_reg,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    input  logic [ADDR_W-1:0]        write_reg,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     regwrite,
    input  logic                     clear_req,
    output logic                     ready
);
    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    rf_state_e state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d, wr_idx;
    logic [DATA_W-1:0] wr_val;
    logic wr_en, user_wr;
    logic [DATA_W-1:0] mem_q [DEPTH];
    // The sweep owns the single write port while clearing; user writes only land in IDLE.
    always_comb begin
        user_wr = regwrite && !clear_req && !(ZERO_REG && (write_reg == '0));
        state_d = state_q;
        clr_idx_d = clr_idx_q;
        wr_en = 1'b0;
        wr_idx = write_reg;
        wr_val = write_data;
        if (state_q == RF_CLEAR) begin
            wr_en = 1'b1;
            wr_idx = clr_idx_q;
            wr_val = '0;
            clr_idx_d = clr_idx_q + ADDR_W'(1);
            state_d = (clr_idx_q == LAST) ? RF_IDLE : RF_CLEAR;
        end else if (clear_req) begin
            state_d = RF_CLEAR;
            clr_idx_d = '0;
        end else begin
            wr_en = user_wr;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem_q[wr_idx] <= wr_val;
    end
    assign ready = (state_q == RF_IDLE);
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        rf_read_port #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS(BYPASS)
        ) u_port (
            .ready(ready),
            .rd_addr(read_reg[i*ADDR_W +: ADDR_W]),
            .mem(mem_q),
            .fwd_en(ready && user_wr),
            .fwd_addr(write_reg),
            .fwd_data(write_data),
            .rd_data(read_data[i*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_param_reg_file.sv
// tb_param_reg_file: directed checks of the register file against a behavioural model.
module tb_param_reg_file;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;
    logic [AW-1:0] rd0 = '0, rd1 = '0, wreg = '0;
    logic [DW-1:0] wdata = '0;
    logic regwrite = 1'b0, clear_req = 1'b0;
    logic [NR*AW-1:0] read_reg;
    logic [NR*DW-1:0] a_rdata, b_rdata;
    logic a_ready, b_ready;
    logic [11:0] c_rreg = '0;
    logic [63:0] c_rdata;
    logic [2:0] c_wreg = '0;
    logic [15:0] c_wdata = '0;
    logic c_regwrite = 1'b0, c_ready;
    int total = 0, bad = 0;
    assign read_reg = {rd1, rd0};

    param_reg_file #(.BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .read_reg(read_reg), .read_data(a_rdata), .write_reg(wreg),
        .write_data(wdata), .regwrite(regwrite), .clear_req(clear_req), .ready(a_ready));
    param_reg_file #(.BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .read_reg(read_reg), .read_data(b_rdata), .write_reg(wreg),
        .write_data(wdata), .regwrite(regwrite), .clear_req(clear_req), .ready(b_ready));
    param_reg_file #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) dut_c (
        .clk(clk), .rst(rst), .read_reg(c_rreg), .read_data(c_rdata), .write_reg(c_wreg),
        .write_data(c_wdata), .regwrite(c_regwrite), .clear_req(1'b0), .ready(c_ready));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Model: the file is either sweeping (reads 0, m_left edges to go) or live with m_mem contents.
    logic [DW-1:0] m_mem [DEPTH];
    bit m_ready = 0, m_live = 0;
    int m_left = 0;
    always @(posedge clk) begin
        if (rst) begin
            m_live = 1;
            m_ready = 0;
            m_left = DEPTH;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1;
                foreach (m_mem[k]) m_mem[k] = '0;
            end
        end else if (clear_req) begin
            m_ready = 0;
            m_left = DEPTH;
        end else if (regwrite && wreg != 0) begin
            m_mem[wreg] = wdata;
        end
    end

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (!m_ready || a == 0) return '0;
        if (byp && regwrite && !clear_req && wreg == a) return wdata;
        return m_mem[a];
    endfunction

    always @(negedge clk) begin
        if (m_live && !rst) begin
            chk("ready_a", 64'(a_ready), 64'(m_ready));
            chk("ready_b", 64'(b_ready), 64'(m_ready));
            chk("rd_a0", 64'(a_rdata[0 +: DW]), 64'(exp_rd(rd0, 1)));
            chk("rd_a1", 64'(a_rdata[DW +: DW]), 64'(exp_rd(rd1, 1)));
            chk("rd_b0", 64'(b_rdata[0 +: DW]), 64'(exp_rd(rd0, 0)));
            chk("rd_b1", 64'(b_rdata[DW +: DW]), 64'(exp_rd(rd1, 0)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (a_ready) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n_a, n_c, n;
        step();
        step();
        settle();
        chk("rst_ready", 64'(a_ready), 0);
        chk("rst_rd", 64'(a_rdata), 0);
        rst = 1'b0;
        n_a = 0;
        n_c = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (c_ready && n_c == 0) n_c = k;
            if (a_ready) begin
                n_a = k;
                break;
            end
        end
        chk("sweep_len", 64'(n_a), 32);
        chk("sweep_len_c", 64'(n_c), 8);
        rd0 = 7;
        rd1 = 31;
        settle();
        chk("cleared_7", 64'(a_rdata[31:0]), 0);
        chk("cleared_31", 64'(a_rdata[63:32]), 0);
        wreg = 7; wdata = 32'hDEADBEEF; regwrite = 1'b1; rd1 = 7;
        settle();
        chk("byp_a", 64'(a_rdata[31:0]), 64'h0000_0000_DEAD_BEEF);
        chk("nobyp_b", 64'(b_rdata[31:0]), 0);
        step();
        regwrite = 1'b0;
        settle();
        chk("wr7_p0", 64'(a_rdata[31:0]), 64'h0000_0000_DEAD_BEEF);
        chk("wr7_p1", 64'(a_rdata[63:32]), 64'h0000_0000_DEAD_BEEF);
        chk("wr7_b", 64'(b_rdata[31:0]), 64'h0000_0000_DEAD_BEEF);
        wreg = 3; wdata = 32'h12345678; regwrite = 1'b1; rd0 = 3;
        settle();
        chk("byp3_a", 64'(a_rdata[31:0]), 64'h0000_0000_1234_5678);
        chk("old3_b", 64'(b_rdata[31:0]), 0);
        step();
        regwrite = 1'b0;
        settle();
        chk("new3_b", 64'(b_rdata[31:0]), 64'h0000_0000_1234_5678);
        wreg = 0; wdata = 32'hFFFFFFFF; regwrite = 1'b1; rd0 = 0;
        settle();
        chk("zero_same", 64'(a_rdata[31:0]), 0);
        step();
        regwrite = 1'b0;
        settle();
        chk("zero_later", 64'(a_rdata[31:0]), 0);
        wreg = 5; wdata = 32'h11; regwrite = 1'b1;
        step();
        regwrite = 1'b0; rd0 = 5;
        settle();
        chk("pre_clear5", 64'(a_rdata[31:0]), 64'h11);
        wdata = 32'hAA; regwrite = 1'b1; clear_req = 1'b1;
        settle();
        chk("clr_no_byp", 64'(a_rdata[31:0]), 64'h11);
        step();
        regwrite = 1'b0; clear_req = 1'b0;
        settle();
        chk("clr_ready_low", 64'(a_ready), 0);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            clear_req = (k == 10);
            step();
            if (a_ready) begin
                n = k;
                break;
            end
        end
        clear_req = 1'b0;
        chk("clr_sweep_len", 64'(n), 32);
        settle();
        chk("clr5_a", 64'(a_rdata[31:0]), 0);
        chk("clr5_b", 64'(b_rdata[31:0]), 0);
        wreg = 9; wdata = 32'h99; regwrite = 1'b1; rd0 = 9;
        step();
        regwrite = 1'b0; clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready(n);
        chk("rst_mid_len", 64'(n), 32);
        settle();
        chk("rst_mid_9", 64'(a_rdata[31:0]), 0);
        c_rreg = {3'd0, 3'd5, 3'd5, 3'd5};
        c_wreg = 5; c_wdata = 16'hBEEF; c_regwrite = 1'b1;
        settle();
        for (int i = 0; i < 4; i++) chk("c_byp", 64'(c_rdata[i*16 +: 16]), (i == 3) ? 64'h0 : 64'hBEEF);
        step();
        c_regwrite = 1'b0;
        settle();
        for (int i = 0; i < 4; i++) chk("c_read", 64'(c_rdata[i*16 +: 16]), (i == 3) ? 64'h0 : 64'hBEEF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
